// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// Everything here is imported by the interface and the supervisor top.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_sup_state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_POR_CYCLES          = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_MAX_RETRIES         = 3;

    localparam int RELOCK_W = 4;

    // Bits needed to hold 0..count-1, never less than one bit.
    function automatic int width_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signals between the lock supervisor, the PLL and the audio-domain consumers.
// ready is a level qualifier, not a handshake: it is high exactly while the FSM is in RUN.
interface pll_lock_supervisor_if;
    import pll_sup_pkg::*;

    logic                pll_locked;
    logic                pll_rst;
    logic                sys_rst;
    logic                ready;
    logic                fault;
    logic [RELOCK_W-1:0] relock_count;
    pll_sup_state_t      state;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output relock_count,
        output state
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  relock_count,
        input  state
    );

endinterface

// File: rtl/bit_sync.sv
// N-flop single-bit synchronizer with asynchronous reset to 0.
// Also used to bring sys_rst into the 12 MHz domain.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies the synchronized lock flag and releases the
// audio-domain reset; retries failed locks a bounded number of times before FAULT.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int POR_CYCLES          = DEF_POR_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.master pll_if
);

    localparam int CNT_W   = width_for(max3(POR_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
    localparam int RETRY_W = width_for(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    pll_sup_state_t      state;
    pll_sup_state_t      next_state;
    logic [CNT_W-1:0]    cnt;
    logic [RETRY_W-1:0]  retry;
    logic [RELOCK_W-1:0] relock;
    logic                locked_s;

    logic pll_rst_d, sys_rst_d, ready_d, fault_d;
    logic pll_rst_q, sys_rst_q, ready_q, fault_q;

    bit_sync #(.N(SYNC_STAGES)) u_locked_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_if.pll_locked),
        .q   (locked_s)
    );

    // State register plus the shared cycle counter, retry and relock counters.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state  <= RESET_PLL;
            cnt    <= '0;
            retry  <= '0;
            relock <= '0;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                cnt <= '0;
            end else if (state == RESET_PLL || state == WAIT_LOCK || state == STABILIZE) begin
                cnt <= cnt + 1'b1;
            end

            if (state == WAIT_LOCK && next_state == RESET_PLL) begin
                retry <= retry + 1'b1;
            end else if (state == STABILIZE && next_state == RUN) begin
                retry <= '0;
            end

            if (state == RUN && next_state == RESET_PLL && relock != {RELOCK_W{1'b1}}) begin
                relock <= relock + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RESET_PLL: begin
                if (cnt == POR_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = (retry == RETRY_MAX) ? FAULT : RESET_PLL;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!locked_s) next_state = RESET_PLL;
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = RESET_PLL;
            end
        endcase
    end

    // Outputs are decoded from next_state and registered, so they change on the
    // same edge as the state and never see a combinational path from pll_locked.
    always_comb begin
        pll_rst_d = 1'b0;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (next_state)
            RESET_PLL: pll_rst_d = 1'b1;
            RUN: begin
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_if.pll_rst      = pll_rst_q;
    assign pll_if.sys_rst      = sys_rst_q;
    assign pll_if.ready        = ready_q;
    assign pll_if.fault        = fault_q;
    assign pll_if.relock_count = relock;
    assign pll_if.state        = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters so every
// pulse, timeout and saturation boundary is reached in a few hundred cycles.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int W = 16;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   passes = 0;
  logic [W-1:0] exp_q[$];

  pll_lock_supervisor_if pll_if ();

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .POR_CYCLES         (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .pll_if(pll_if)
  );

  // clock / reset
  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit after "edge 0", the last edge seen in reset.
  task automatic do_reset();
    rst = 1'b1;
    pll_if.pll_locked = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_if.pll_locked = 1'b0;
    step(2);
    checks++; if (pll_if.pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b expected 1", pll_if.pll_rst); else passes++;
    checks++; if (pll_if.sys_rst !== 1'b1) $display("FAIL reset_sys_rst: got %b expected 1", pll_if.sys_rst); else passes++;
    checks++; if (pll_if.ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", pll_if.ready); else passes++;
    checks++; if (pll_if.fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", pll_if.fault); else passes++;
    checks++; if (pll_if.relock_count !== 4'd0) $display("FAIL reset_relock: got %0d expected 0", pll_if.relock_count); else passes++;
    checks++; if (pll_if.state !== RESET_PLL) $display("FAIL reset_state: got %0d expected %0d", pll_if.state, RESET_PLL); else passes++;
  endtask

  task automatic test_normal_lock();
    int n;
    logic early;
    do_reset();
    n = 0;
    while (pll_if.pll_rst === 1'b1 && n < 50) begin
      n++;
      step();
    end
    checks++; if (n != 4) $display("FAIL normal_por_width: got %0d expected 4", n); else passes++;
    checks++; if (pll_if.state !== WAIT_LOCK) $display("FAIL normal_wait_state: got %0d expected %0d", pll_if.state, WAIT_LOCK); else passes++;
    step(6);
    pll_if.pll_locked = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pll_if.ready !== 1'b0 || pll_if.sys_rst !== 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) $display("FAIL normal_early_ready: got %b expected 0", early); else passes++;
    step();
    checks++; if (pll_if.ready !== 1'b1) $display("FAIL normal_ready: got %b expected 1", pll_if.ready); else passes++;
    checks++; if (pll_if.sys_rst !== 1'b0) $display("FAIL normal_sys_rst: got %b expected 0", pll_if.sys_rst); else passes++;
    checks++; if (pll_if.fault !== 1'b0) $display("FAIL normal_fault: got %b expected 0", pll_if.fault); else passes++;
    checks++; if (pll_if.relock_count !== 4'd0) $display("FAIL normal_relock: got %0d expected 0", pll_if.relock_count); else passes++;
  endtask

  task automatic test_glitch();
    logic bad;
    logic saw_stab;
    do_reset();
    step(6);
    bad = 1'b0;
    saw_stab = 1'b0;
    pll_if.pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pll_if.ready !== 1'b0 || pll_if.pll_rst !== 1'b0) bad = 1'b1;
      if (pll_if.state === STABILIZE) saw_stab = 1'b1;
    end
    pll_if.pll_locked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pll_if.ready !== 1'b0 || pll_if.pll_rst !== 1'b0) bad = 1'b1;
    end
    checks++; if (pll_if.state !== WAIT_LOCK) $display("FAIL glitch_back_to_wait: got %0d expected %0d", pll_if.state, WAIT_LOCK); else passes++;
    pll_if.pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pll_if.ready !== 1'b0 || pll_if.pll_rst !== 1'b0) bad = 1'b1;
    end
    step();
    checks++; if (saw_stab !== 1'b1) $display("FAIL glitch_saw_stabilize: got %b expected 1", saw_stab); else passes++;
    checks++; if (bad !== 1'b0) $display("FAIL glitch_spurious_output: got %b expected 0", bad); else passes++;
    checks++; if (pll_if.ready !== 1'b1) $display("FAIL glitch_ready: got %b expected 1", pll_if.ready); else passes++;
    checks++; if (pll_if.sys_rst !== 1'b0) $display("FAIL glitch_sys_rst: got %b expected 0", pll_if.sys_rst); else passes++;
  endtask

  // Scoreboard: expected pll_rst transition edges, counted from the last reset edge.
  task automatic test_never_locks();
    logic prev;
    logic [W-1:0] exp_cyc;
    int fault_first;
    exp_q = {};
    exp_q.push_back(16'd4);
    exp_q.push_back(16'd36);
    exp_q.push_back(16'd40);
    exp_q.push_back(16'd72);
    exp_q.push_back(16'd76);
    exp_q.push_back(16'd108);
    do_reset();
    prev = pll_if.pll_rst;
    fault_first = -1;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      step();
      if (pll_if.pll_rst !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL never_unexpected_edge: got edge at %0d expected none", cyc);
        end else begin
          exp_cyc = exp_q.pop_front();
          if (W'(cyc) !== exp_cyc) $display("FAIL never_edge_time: got %0d expected %0d", cyc, exp_cyc);
          else passes++;
        end
        prev = pll_if.pll_rst;
      end
      if (fault_first < 0 && pll_if.fault === 1'b1) fault_first = cyc;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL never_missing_edges: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (fault_first != 108) $display("FAIL never_fault_time: got %0d expected 108", fault_first); else passes++;
    checks++; if (pll_if.pll_rst !== 1'b1) $display("FAIL never_pll_rst_held: got %b expected 1", pll_if.pll_rst); else passes++;
    checks++; if (pll_if.sys_rst !== 1'b1) $display("FAIL never_sys_rst_held: got %b expected 1", pll_if.sys_rst); else passes++;
    pll_if.pll_locked = 1'b1;
    step(20);
    checks++; if (pll_if.fault !== 1'b1) $display("FAIL never_fault_sticky: got %b expected 1", pll_if.fault); else passes++;
    checks++; if (pll_if.ready !== 1'b0) $display("FAIL never_ready: got %b expected 0", pll_if.ready); else passes++;
    checks++; if (pll_if.state !== FAULT) $display("FAIL never_state: got %0d expected %0d", pll_if.state, FAULT); else passes++;
  endtask

  task automatic test_loss_in_run();
    int n;
    do_reset();
    step(4);
    pll_if.pll_locked = 1'b1;
    step(11);
    checks++; if (pll_if.ready !== 1'b1) $display("FAIL loss_initial_ready: got %b expected 1", pll_if.ready); else passes++;
    pll_if.pll_locked = 1'b0;
    step(3);
    checks++; if (pll_if.sys_rst !== 1'b1) $display("FAIL loss_sys_rst: got %b expected 1", pll_if.sys_rst); else passes++;
    checks++; if (pll_if.ready !== 1'b0) $display("FAIL loss_ready: got %b expected 0", pll_if.ready); else passes++;
    checks++; if (pll_if.relock_count !== 4'd1) $display("FAIL loss_relock: got %0d expected 1", pll_if.relock_count); else passes++;
    n = 0;
    while (pll_if.pll_rst === 1'b1 && n < 50) begin
      n++;
      step();
    end
    checks++; if (n != 4) $display("FAIL loss_por_width: got %0d expected 4", n); else passes++;
    pll_if.pll_locked = 1'b1;
    step(11);
    checks++; if (pll_if.ready !== 1'b1) $display("FAIL loss_relock_ready: got %b expected 1", pll_if.ready); else passes++;
    checks++; if (pll_if.relock_count !== 4'd1) $display("FAIL loss_relock_kept: got %0d expected 1", pll_if.relock_count); else passes++;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    step(4);
    pll_if.pll_locked = 1'b1;
    step(11);
    for (int i = 0; i < 17; i++) begin
      pll_if.pll_locked = 1'b0;
      step(3);
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (pll_if.relock_count !== 4'(exp_cnt)) $display("FAIL sat_relock_%0d: got %0d expected %0d", i, pll_if.relock_count, exp_cnt);
      else passes++;
      step(4);
      pll_if.pll_locked = 1'b1;
      step(11);
    end
    checks++; if (pll_if.ready !== 1'b1) $display("FAIL sat_ready: got %b expected 1", pll_if.ready); else passes++;
    checks++; if (pll_if.relock_count !== 4'd15) $display("FAIL sat_final: got %0d expected 15", pll_if.relock_count); else passes++;
  endtask

  // Runs from the saturated RUN state left by test_saturation.
  task automatic test_async_reset();
    pll_if.pll_locked = 1'b0;
    step(7);
    pll_if.pll_locked = 1'b1;
    step(4);
    checks++; if (pll_if.state !== STABILIZE) $display("FAIL async_pre_state: got %0d expected %0d", pll_if.state, STABILIZE); else passes++;
    checks++; if (pll_if.relock_count !== 4'd15) $display("FAIL async_pre_relock: got %0d expected 15", pll_if.relock_count); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pll_if.pll_rst !== 1'b1) $display("FAIL async_pll_rst: got %b expected 1", pll_if.pll_rst); else passes++;
    checks++; if (pll_if.sys_rst !== 1'b1) $display("FAIL async_sys_rst: got %b expected 1", pll_if.sys_rst); else passes++;
    checks++; if (pll_if.ready !== 1'b0) $display("FAIL async_ready: got %b expected 0", pll_if.ready); else passes++;
    checks++; if (pll_if.fault !== 1'b0) $display("FAIL async_fault: got %b expected 0", pll_if.fault); else passes++;
    checks++; if (pll_if.relock_count !== 4'd0) $display("FAIL async_relock: got %0d expected 0", pll_if.relock_count); else passes++;
    checks++; if (pll_if.state !== RESET_PLL) $display("FAIL async_state: got %0d expected %0d", pll_if.state, RESET_PLL); else passes++;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    pll_if.pll_locked = 1'b0;
    test_reset();
    test_normal_lock();
    test_glitch();
    test_never_locks();
    test_loss_in_run();
    test_saturation();
    test_async_reset();
    // final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
